// File: rtl/crypto_sched_pkg.sv
// Shared widths and FSM state encoding for the crypto job scheduler.
package crypto_sched_pkg;

    localparam int DATA_W  = 128;
    localparam int KEY_W   = 256;
    localparam int NUM_REQ = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BUSY,
        ST_RESP,
        ST_CLEAR
    } sched_state_e;

endpackage

// File: rtl/crypto_sched_if.sv
// Requester-side request/response bus of the crypto job scheduler.
interface crypto_sched_if;
    import crypto_sched_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*KEY_W-1:0]  req_key;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ-1:0]        resp_ready;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_err;

    modport master (
        output req_valid, req_data, req_key, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_data, req_key, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/crypto_sched_rr_arb.sv
// Two-way round-robin arbiter; the pointer remembers the last granted requester.
module crypto_sched_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_one;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_one ? 2'b01 : 2'b10;
        end
    end

    // Reset value 1 makes requester 0 the first winner under contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_one <= 1'b1;
        end else if (update && gnt != 2'b00) begin
            last_one <= gnt[1];
        end
    end

endmodule

// File: rtl/crypto_job_sched.sv
// Crypto job scheduler: arbitrates two requesters onto one cipher core.
// Define CRYPTO_SCHED_WDOG_EN to enable the BUSY-state timeout abort.
//   state | meaning
//   IDLE  | waiting for a request, grant offered
//   LOAD  | start pulse, captured data/key presented to core
//   BUSY  | waiting for core_valid (or watchdog)
//   RESP  | result held until the granted requester accepts
//   CLEAR | core reset pulse, secrets wiped
module crypto_job_sched
    import crypto_sched_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst,
    crypto_sched_if.slave      bus,
    output logic               busy,
    output logic               core_rst,
    output logic               core_start,
    output logic [DATA_W-1:0]  core_data,
    output logic [KEY_W-1:0]   core_key,
    input  logic [DATA_W-1:0]  core_result,
    input  logic               core_valid
);

    sched_state_e       state;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] gnt_q;
    logic [DATA_W-1:0]  data_q;
    logic [KEY_W-1:0]   key_q;
    logic [DATA_W-1:0]  resp_q;
    logic [DATA_W-1:0]  sel_data;
    logic [KEY_W-1:0]   sel_key;
    logic               fire;
    logic               timeout_hit;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("TIMEOUT must be at least 1");
    end

    crypto_sched_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .update (fire),
        .gnt    (gnt)
    );

    // Ready is gated by rst so every output is quiet while reset is held.
    assign bus.req_ready = (state == ST_IDLE && !rst) ? gnt : '0;
    assign fire          = |(bus.req_valid & bus.req_ready);
    assign sel_data      = gnt[1] ? bus.req_data[DATA_W +: DATA_W] : bus.req_data[0 +: DATA_W];
    assign sel_key       = gnt[1] ? bus.req_key[KEY_W +: KEY_W]    : bus.req_key[0 +: KEY_W];

`ifdef CRYPTO_SCHED_WDOG_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt;
    logic             err_q;

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // A core_valid arriving on the terminal cycle still wins over the abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (state == ST_BUSY) begin
            cnt <= cnt + 1'b1;
            if (core_valid || timeout_hit) begin
                err_q <= !core_valid;
            end
        end else begin
            cnt <= '0;
            if (state == ST_CLEAR) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.resp_err = (state == ST_RESP) && err_q;
`else
    assign timeout_hit  = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            gnt_q  <= '0;
            data_q <= '0;
            key_q  <= '0;
            resp_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        gnt_q  <= gnt;
                        data_q <= sel_data;
                        key_q  <= sel_key;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: state <= ST_BUSY;
                ST_BUSY: begin
                    if (core_valid) begin
                        resp_q <= core_result;
                        state  <= ST_RESP;
                    end else if (timeout_hit) begin
                        resp_q <= '0;
                        state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (|(bus.resp_ready & gnt_q)) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    gnt_q  <= '0;
                    data_q <= '0;
                    key_q  <= '0;
                    resp_q <= '0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy           = (state != ST_IDLE);
    assign core_rst       = rst || (state == ST_CLEAR);
    assign core_start     = (state == ST_LOAD);
    assign core_data      = (state == ST_LOAD) ? data_q : '0;
    assign core_key       = (state == ST_LOAD) ? key_q  : '0;
    assign bus.resp_valid = (state == ST_RESP) ? gnt_q  : '0;
    assign bus.resp_data  = (state == ST_RESP) ? resp_q : '0;

endmodule

// File: tb/tb_crypto_job_sched.sv
// Self-checking bench for crypto_job_sched: directed and random jobs against a reference model.
module tb_crypto_job_sched;

    localparam int TIMEOUT = 32;
`ifdef CRYPTO_SCHED_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         busy;
    logic         core_rst;
    logic         core_start;
    logic [127:0] core_data;
    logic [255:0] core_key;
    logic [127:0] core_result = '0;
    logic         core_valid  = 1'b0;

    crypto_sched_if bus ();

    crypto_job_sched #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .core_rst    (core_rst),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_key    (core_key),
        .core_result (core_result),
        .core_valid  (core_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core stand-in: raises sticky valid lat_cfg cycles after the start pulse (never if negative).
    int           lat_cfg = -1;
    logic [127:0] res_cfg = '0;
    int           core_n  = 0;
    bit           core_on = 1'b0;

    always @(negedge clk) begin
        if (core_rst) begin
            core_valid  = 1'b0;
            core_result = '0;
            core_on     = 1'b0;
        end else if (core_start) begin
            core_on = 1'b1;
            core_n  = 0;
        end else if (core_on) begin
            core_n++;
            if (core_n == lat_cfg) begin
                core_valid  = 1'b1;
                core_result = res_cfg;
                core_on     = 1'b0;
            end
        end
    end

    // Invariants sampled every cycle; also counts start and core-reset pulses.
    int start_cnt = 0;
    int crst_cnt  = 0;

    always @(negedge clk) begin
        #1;
        if (core_start) start_cnt++;
        if (core_rst)   crst_cnt++;
        check("key_hygiene", ((core_key != '0) || (core_data != '0)) && !core_start, 1'b0);
        check("resp_valid_onehot", $countones(bus.resp_valid) <= 1, 1'b1);
        check("req_ready_idle_only", ($countones(bus.req_ready) <= 1) && !(busy && bus.req_ready != '0), 1'b1);
        check("resp_data_zero", (bus.resp_valid == '0) && (bus.resp_data != '0), 1'b0);
    end

    // Reference state: last granted requester and the offered payloads.
    int           last_ref = 1;
    logic [127:0] dat [2];
    logic [255:0] key [2];

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_job(input logic [1:0] vreq, input int lat, input logic [127:0] res,
                           input int hold, input string tag);
        int           w;
        int           n;
        int           dur;
        bit           to;
        logic [1:0]   wmask;
        logic [127:0] exp_data;
        // Round robin: under contention the requester not granted last wins.
        if (vreq == 2'b11) w = (last_ref == 1) ? 0 : 1;
        else               w = vreq[1] ? 1 : 0;
        wmask    = 2'b01 << w;
        to       = WDOG && (lat < 0 || lat > TIMEOUT);
        dur      = to ? TIMEOUT : lat;
        exp_data = to ? '0 : res;
        lat_cfg  = lat;
        res_cfg  = res;
        start_cnt = 0;
        crst_cnt  = 0;
        bus.req_data  = {dat[1], dat[0]};
        bus.req_key   = {key[1], key[0]};
        bus.req_valid = vreq;
        #1;
        check({tag, "/req_ready"}, bus.req_ready, wmask);
        @(posedge clk);
        #1;
        bus.req_data = ~bus.req_data;
        bus.req_key  = ~bus.req_key;
        @(negedge clk);
        check({tag, "/load_start"}, core_start, 1'b1);
        check({tag, "/load_data"}, core_data, dat[w]);
        check({tag, "/load_key"}, core_key, key[w]);
        check({tag, "/load_busy"}, busy, 1'b1);
        bus.req_valid = vreq & ~wmask;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.resp_valid == '0 && n < 200);
        check({tag, "/busy_cycles"}, n - 1, dur);
        check({tag, "/resp_valid"}, bus.resp_valid, wmask);
        check({tag, "/resp_data"}, bus.resp_data, exp_data);
        check({tag, "/resp_err"}, bus.resp_err, to);
        bus.resp_ready = ~wmask;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, bus.resp_valid, wmask);
            check({tag, "/hold_data"}, bus.resp_data, exp_data);
            check({tag, "/hold_req_ready"}, bus.req_ready, 2'b00);
        end
        bus.resp_ready = wmask;
        @(negedge clk);
        check({tag, "/clear_core_rst"}, core_rst, 1'b1);
        check({tag, "/clear_resp_valid"}, bus.resp_valid, 2'b00);
        bus.resp_ready = 2'b00;
        @(negedge clk);
        check({tag, "/idle_busy"}, busy, 1'b0);
        check({tag, "/start_pulses"}, start_cnt, 1);
        check({tag, "/core_rst_pulses"}, crst_cnt, 1);
        last_ref = w;
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 2'b11;
        bus.resp_ready = 2'b00;
        bus.req_data   = {r128(), r128()};
        bus.req_key    = {r128(), r128(), r128(), r128()};
        repeat (3) @(negedge clk);
        check("rst/busy", busy, 1'b0);
        check("rst/core_rst", core_rst, 1'b1);
        check("rst/core_start", core_start, 1'b0);
        check("rst/core_key", core_key, '0);
        check("rst/core_data", core_data, '0);
        check("rst/req_ready", bus.req_ready, 2'b00);
        check("rst/resp_valid", bus.resp_valid, 2'b00);
        check("rst/resp_err", bus.resp_err, 1'b0);

        // Single request right on reset release.
        rst    = 1'b0;
        dat[0] = 128'h1;
        key[0] = {32{8'hA5}};
        dat[1] = r128();
        key[1] = {r128(), r128()};
        run_job(2'b01, 16, 128'hDEAD, 0, "single");

        // Short pulse that drops before a clock edge must not start a job.
        bus.req_valid = 2'b01;
        #2 bus.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        check("drop/busy", busy, 1'b0);

        dat[1] = r128();
        key[1] = {r128(), r128()};
        run_job(2'b10, 5, r128(), 0, "req1");

        for (int j = 0; j < 3; j++) begin
            dat[0] = r128(); key[0] = {r128(), r128()};
            dat[1] = r128(); key[1] = {r128(), r128()};
            run_job(2'b11, 3 + j, r128(), (j == 1) ? 10 : 0, "contend");
        end

        for (int j = 0; j < 8; j++) begin
            logic [1:0] vr;
            vr = 2'($urandom_range(3, 1));
            dat[0] = r128(); key[0] = {r128(), r128()};
            dat[1] = r128(); key[1] = {r128(), r128()};
            run_job(vr, int'($urandom_range(40, 1)), r128(), int'($urandom_range(3, 0)), "random");
        end

`ifdef CRYPTO_SCHED_WDOG_EN
        run_job(2'b01, TIMEOUT, r128(), 0, "wdog_edge_valid");
        run_job(2'b10, TIMEOUT + 1, r128(), 0, "wdog_late");
        run_job(2'b11, -1, r128(), 2, "wdog_never");
`else
        run_job(2'b01, 60, r128(), 0, "no_wdog_long");
`endif

        // Reset during BUSY cycle 5 of a job granted to requester 0.
        dat[0] = r128(); key[0] = {r128(), r128()};
        bus.req_data  = {dat[1], dat[0]};
        bus.req_key   = {key[1], key[0]};
        lat_cfg       = -1;
        bus.req_valid = 2'b01;
        @(negedge clk);
        check("midrst/load", core_start, 1'b1);
        bus.req_valid = 2'b11;
        repeat (5) @(negedge clk);
        check("midrst/in_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst/busy", busy, 1'b0);
        check("midrst/core_rst", core_rst, 1'b1);
        check("midrst/req_ready", bus.req_ready, 2'b00);
        check("midrst/core_key", core_key, '0);
        check("midrst/resp_valid", bus.resp_valid, 2'b00);
        @(negedge clk);
        rst      = 1'b0;
        last_ref = 1;
        dat[0] = r128(); key[0] = {r128(), r128()};
        dat[1] = r128(); key[1] = {r128(), r128()};
        run_job(2'b11, 7, r128(), 1, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crypto_job_sched.md
CRYPTO_JOB_SCHED -- requirements
Module: crypto_job_sched

Interface
REQ-001 Parameter TIMEOUT, default 32, maximum BUSY-state cycles before a job is aborted.
REQ-002 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port rst  in  1  reset, asynchronous, active-high.
REQ-004 Port req_valid  in  2  per-requester job request.
REQ-005 Port req_ready  out  2  per-requester accept; one-hot or zero.
REQ-006 Port req_data  in  256  two 128-bit plaintexts; requester i at bits [128*i +: 128].
REQ-007 Port req_key  in  512  two 256-bit keys; requester i at bits [256*i +: 256].
REQ-008 Port resp_valid  out  2  per-requester result valid; one-hot or zero.
REQ-009 Port resp_ready  in  2  per-requester result accept.
REQ-010 Port resp_data  out  128  result for the granted requester.
REQ-011 Port resp_err  out  1  result is a timeout abort.
REQ-012 Port busy  out  1  high in every state except IDLE.
REQ-013 Port core_rst  out  1  synchronous reset to the cipher core.
REQ-014 Port core_start  out  1  one-cycle start pulse to the core.
REQ-015 Port core_data  out  128  plaintext to the core.
REQ-016 Port core_key  out  256  key to the core.
REQ-017 Port core_result  in  128  core output data.
REQ-018 Port core_valid  in  1  core output valid; sticky until core_rst.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD, BUSY, RESP and CLEAR, with transitions IDLE->LOAD->BUSY->RESP->CLEAR->IDLE.
REQ-020 In IDLE with any req_valid high, the block SHALL grant one requester round-robin, preferring the requester not granted last; the last-grant pointer resets to 1, so requester 0 wins first.
REQ-021 req_ready[g] SHALL be high only in IDLE, combinationally, for the granted requester; on valid&ready, data and key SHALL be captured into internal registers and the FSM SHALL go to LOAD.
REQ-022 req_ready SHALL be 0 in every non-IDLE state; a requester dropping req_valid before its grant SHALL cause no capture.
REQ-023 In LOAD, core_start SHALL be 1 for exactly one cycle, with core_data/core_key equal to the captured values; the FSM SHALL go to BUSY next.
REQ-024 core_key and core_data SHALL be all-zero in every state except LOAD.
REQ-025 In BUSY, a cycle counter SHALL increment from 0; core_valid=1 SHALL latch core_result into the response register, clear resp_err and move the FSM to RESP.
REQ-026 If the counter reaches TIMEOUT-1 without core_valid, the FSM SHALL go to RESP with resp_data=0 and resp_err=1; if core_valid arrives in that same cycle, the valid result SHALL win.
REQ-027 In RESP, resp_valid[g] SHALL be held with stable resp_data/resp_err until resp_ready[g]=1, then the FSM SHALL go to CLEAR.
REQ-028 In CLEAR, core_rst SHALL be 1 for exactly one cycle, the captured key, data and response registers SHALL be zeroed, and the FSM SHALL go to IDLE.
REQ-029 resp_data SHALL read zero whenever resp_valid is 0.

Reset
REQ-030 While rst=1, the block SHALL drive: FSM IDLE, counter 0, all captured and response registers 0, last-grant pointer 1, all outputs 0 except core_rst=1.
REQ-031 core_rst SHALL be the OR of rst and the CLEAR state, so a reset mid-job also clears the core.
REQ-032 After reset deasserts, the block SHALL accept a request on the first clock edge.

Configuration
REQ-033 With CRYPTO_SCHED_WDOG_EN defined, the block SHALL implement the REQ-026 timeout; without it, the counter SHALL be absent, BUSY SHALL wait indefinitely for core_valid, and resp_err SHALL be tied to 0.

Structure
REQ-034 Package crypto_sched_pkg SHALL hold the FSM state enum and the constants DATA_W=128, KEY_W=256 and NUM_REQ=2.
REQ-035 The two-way round-robin grant logic SHALL be the sub-module crypto_sched_rr_arb, with inputs req[1:0], update and rst, and output gnt[1:0].

Verification
REQ-036 Single request: requester 0 sends data=128'h1 and key=256'hA5..A5, and a core model asserts valid 16 cycles after start with result=128'hDEAD -> exactly one start pulse, resp_valid=2'b01, resp_data=128'hDEAD, resp_err=0, then one core_rst pulse.
REQ-037 Contention: both requesters hold req_valid for three jobs -> grant order 0,1,0, and at most one resp_valid bit is set at a time.
REQ-038 Watchdog (macro defined, TIMEOUT=32): the core never asserts valid -> resp_err=1 and resp_data=0 in the 32nd BUSY cycle, followed by a CLEAR pulse.
REQ-039 Backpressure: resp_ready is held low for 10 cycles -> resp_valid and resp_data stay stable, and req_ready stays 0 throughout.
REQ-040 Reset in BUSY: rst is asserted for 1 cycle at BUSY cycle 5 -> all outputs return to reset values asynchronously, core_rst=1, and a next request is accepted normally.
REQ-041 Key hygiene: over the full scenario set, core_key is non-zero only in LOAD cycles.
